// File: rtl/sk6812_chain_driver.sv
// rtl/sk6812_chain_driver.sv - SK6812 LED chain serial driver with on-chip frame buffer
//
// Parameters:
//   CLK_HZ, NUM_PIXELS (1..1024), BITS_PER_PIXEL (24 = GRB, 32 = GRBW),
//   T0H_NS / T1H_NS / TBIT_NS bit timing, RESET_US latch gap.
// Ports:
//   SysClk     - single clock, rising edge
//   RstN       - asynchronous active-low reset
//   PixWrEn    - frame-buffer write strobe (accepted in every state)
//   PixAddr    - pixel index to write, 0 is nearest the FPGA
//   PixData    - packed pixel, G in the top byte, then R, B, [W]
//   Bright     - global brightness, latched when a frame is accepted
//   StartFrame - request to send the whole buffer (ignored while busy)
//   Busy       - high from frame acceptance until the latch gap ends
//   FrameDone  - one-cycle pulse at frame completion
//   SK6812o    - serial data line to the chain

module sk6812_chain_driver #(
    parameter int CLK_HZ         = 50000000,
    parameter int NUM_PIXELS     = 8,
    parameter int BITS_PER_PIXEL = 24,
    parameter int T0H_NS         = 300,
    parameter int T1H_NS         = 600,
    parameter int TBIT_NS        = 1250,
    parameter int RESET_US       = 80,
    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic                      SysClk,
    input  logic                      RstN,
    input  logic                      PixWrEn,
    input  logic [AW-1:0]             PixAddr,
    input  logic [BITS_PER_PIXEL-1:0] PixData,
    input  logic [7:0]                Bright,
    input  logic                      StartFrame,
    output logic                      Busy,
    output logic                      FrameDone,
    output logic                      SK6812o
);

    localparam int CYC_PER_US = CLK_HZ / 1000000;
    localparam int T0H_CYC    = CYC_PER_US * T0H_NS / 1000;
    localparam int T1H_CYC    = CYC_PER_US * T1H_NS / 1000;
    localparam int TBIT_CYC   = CYC_PER_US * TBIT_NS / 1000;
    localparam int RESET_CYC  = CYC_PER_US * RESET_US;
    localparam int NBYTES     = BITS_PER_PIXEL / 8;

    localparam int PH_W  = $clog2(TBIT_CYC + 1);
    localparam int LAT_W = $clog2(RESET_CYC + 1);
    localparam int BIT_W = $clog2(BITS_PER_PIXEL);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TBIT_CYC - 1);
    localparam logic [PH_W-1:0]  T0H_L    = PH_W'(T0H_CYC);
    localparam logic [PH_W-1:0]  T1H_L    = PH_W'(T1H_CYC);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [AW-1:0]    PIX_LAST = AW'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT,
        ST_LATCH
    } state_t;

    // Brightness 255 is treated as full scale so a saturated level stays saturated;
    // every other level keeps the upper byte of the 8x8 product.
    function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] br);
        if (br == 8'hFF)
            return b;
        return 8'(({8'd0, b} * {8'd0, br}) >> 8);
    endfunction

    logic [BITS_PER_PIXEL-1:0] frame_buf [NUM_PIXELS];

    state_t                    state, state_n;
    logic [AW-1:0]             pix_idx, pix_idx_n;
    logic [BIT_W-1:0]          bit_idx, bit_idx_n;
    logic [PH_W-1:0]           phase, phase_n;
    logic [LAT_W-1:0]          latch_cnt, latch_n;
    logic [BITS_PER_PIXEL-1:0] shreg, shreg_n;
    logic [7:0]                bright_q, bright_n;
    logic                      busy_n, done_n, sk_n;

    logic [AW-1:0]             rd_idx;
    logic [BITS_PER_PIXEL-1:0] rd_pix, scaled;
    logic [PH_W-1:0]           high_len;
    logic                      wr_ok;

    // Frame buffer: no reset, writable at any time.
    assign wr_ok = PixWrEn && (int'(PixAddr) < NUM_PIXELS);

    always_ff @(posedge SysClk) begin
        if (wr_ok)
            frame_buf[PixAddr] <= PixData;
    end

    // LOAD reads the current index; during a bit period the read looks one pixel
    // ahead so the next pixel can be loaded on the final low cycle of the last bit.
    assign rd_idx = (state == ST_LOAD || pix_idx == PIX_LAST) ? pix_idx : pix_idx + AW'(1);
    assign rd_pix = frame_buf[rd_idx];

    always_comb begin
        scaled = '0;
        for (int i = 0; i < NBYTES; i++)
            scaled[i*8 +: 8] = scale_byte(rd_pix[i*8 +: 8], bright_q);
    end

    always_ff @(posedge SysClk or negedge RstN) begin
        if (!RstN) begin
            state     <= ST_IDLE;
            pix_idx   <= '0;
            bit_idx   <= '0;
            phase     <= '0;
            latch_cnt <= '0;
            shreg     <= '0;
            bright_q  <= '0;
            Busy      <= 1'b0;
            FrameDone <= 1'b0;
            SK6812o   <= 1'b0;
        end else begin
            state     <= state_n;
            pix_idx   <= pix_idx_n;
            bit_idx   <= bit_idx_n;
            phase     <= phase_n;
            latch_cnt <= latch_n;
            shreg     <= shreg_n;
            bright_q  <= bright_n;
            Busy      <= busy_n;
            FrameDone <= done_n;
            SK6812o   <= sk_n;
        end
    end

    always_comb begin
        state_n   = state;
        pix_idx_n = pix_idx;
        bit_idx_n = bit_idx;
        phase_n   = phase;
        latch_n   = latch_cnt;
        shreg_n   = shreg;
        bright_n  = bright_q;
        done_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                // FrameDone is high during the first idle cycle; a start there is dropped.
                if (StartFrame && !FrameDone) begin
                    state_n   = ST_LOAD;
                    bright_n  = Bright;
                    pix_idx_n = '0;
                end
            end
            ST_LOAD: begin
                shreg_n   = scaled;
                bit_idx_n = '0;
                phase_n   = '0;
                state_n   = ST_BIT;
            end
            ST_BIT: begin
                if (phase == PH_LAST) begin
                    phase_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_n = '0;
                        if (pix_idx == PIX_LAST) begin
                            state_n = ST_LATCH;
                            latch_n = '0;
                        end else begin
                            pix_idx_n = pix_idx + AW'(1);
                            shreg_n   = scaled;
                        end
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                        shreg_n   = shreg << 1;
                    end
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            ST_LATCH: begin
                if (latch_cnt == LAT_LAST) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    latch_n = latch_cnt + LAT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are registered from the next-cycle view of the bit engine.
        high_len = shreg_n[BITS_PER_PIXEL-1] ? T1H_L : T0H_L;
        sk_n     = (state_n == ST_BIT) && (phase_n < high_len);
        busy_n   = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_sk6812_chain_driver.sv
// tb/tb_sk6812_chain_driver.sv - randomized self-checking bench for sk6812_chain_driver

module tb_sk6812_chain_driver;

    localparam int CLK_HZ   = 50000000;
    localparam int CPU      = CLK_HZ / 1000000;
    localparam int T0H      = CPU * 300 / 1000;
    localparam int T1H      = CPU * 600 / 1000;
    localparam int TBIT     = CPU * 1250 / 1000;
    localparam int RST_MAIN = CPU * 80;
    localparam int RST_W    = CPU * 4;
    localparam int NPIX     = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_wr_en = 1'b0;
    logic [2:0]  pix_addr = '0;
    logic [23:0] pix_data = '0;
    logic [7:0]  bright = '0;
    logic        start_frame = 1'b0;
    logic        busy, frame_done, sk;

    logic        w_wr_en = 1'b0;
    logic [0:0]  w_addr = '0;
    logic [31:0] w_data = '0;
    logic        w_start = 1'b0;
    logic        w_busy, w_done, w_sk;

    always #10 clk = ~clk;

    sk6812_chain_driver u_dut (
        .SysClk(clk), .RstN(rst_n), .PixWrEn(pix_wr_en), .PixAddr(pix_addr),
        .PixData(pix_data), .Bright(bright), .StartFrame(start_frame),
        .Busy(busy), .FrameDone(frame_done), .SK6812o(sk)
    );

    sk6812_chain_driver #(.NUM_PIXELS(1), .BITS_PER_PIXEL(32), .RESET_US(4)) u_dut_w (
        .SysClk(clk), .RstN(rst_n), .PixWrEn(w_wr_en), .PixAddr(w_addr),
        .PixData(w_data), .Bright(bright), .StartFrame(w_start),
        .Busy(w_busy), .FrameDone(w_done), .SK6812o(w_sk)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: buffer contents and the pixel values each frame should send.
    logic [31:0] fb [NPIX];
    logic [31:0] fbw;
    logic [31:0] exp_pix [NPIX];

    function automatic logic [7:0] scale(input logic [7:0] b, input logic [7:0] br);
        int p;
        if (br == 8'd255)
            return b;
        p = int'(b) * int'(br) / 256;
        return 8'(p);
    endfunction

    function automatic bit exp_bit(input int k, input int bpp, input logic [7:0] br);
        int         p, pos;
        logic [7:0] raw, sc;
        p   = k / bpp;
        pos = bpp - 1 - (k % bpp);
        raw = exp_pix[p][(pos / 8) * 8 +: 8];
        sc  = scale(raw, br);
        return sc[pos % 8];
    endfunction

    bit smp_sk[$];
    bit smp_busy[$];
    int done_j;
    bit aborted;
    int opt_mid_start = -1;
    int opt_wr_j = -1;
    int opt_rst_j = -1;
    bit opt_start_on_done = 0;
    logic [23:0] wr_val2, wr_val5;

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) w_start = v;
        else start_frame = v;
    endtask

    task automatic write_now(input int a, input logic [23:0] v, input int cur);
        pix_wr_en = 1'b1;
        pix_addr  = 3'(a);
        pix_data  = v;
        fb[a]     = {8'd0, v};
        if (a > cur) exp_pix[a] = {8'd0, v};
    endtask

    task automatic write_idle(input int a, input logic [23:0] v);
        @(negedge clk);
        pix_wr_en = 1'b1;
        pix_addr  = 3'(a);
        pix_data  = v;
        fb[a]     = {8'd0, v};
        @(negedge clk);
        pix_wr_en = 1'b0;
    endtask

    task automatic w_write(input int a, input logic [31:0] v);
        @(negedge clk);
        w_wr_en = 1'b1;
        w_addr  = 1'(a);
        w_data  = v;
        if (a == 0) fbw = v;
        @(negedge clk);
        w_wr_en = 1'b0;
    endtask

    task automatic run_frame(input int sel, input int npix, input int bpp, input int rst_c);
        int         nb, flen, cur, lead, tot, hi, bad, j;
        bit         inrun, s;
        logic [7:0] br;
        nb   = npix * bpp;
        flen = 2 + nb * TBIT + rst_c;
        br   = bright;
        for (int p = 0; p < npix; p++) exp_pix[p] = (sel != 0) ? fbw : fb[p];
        smp_sk.delete();
        smp_busy.delete();
        done_j  = -1;
        aborted = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int jj = 1; jj <= flen + 20 && done_j < 0 && !aborted; jj++) begin
            @(negedge clk);
            set_start(sel, 1'b0);
            pix_wr_en = 1'b0;
            smp_sk.push_back((sel != 0) ? w_sk : sk);
            smp_busy.push_back((sel != 0) ? w_busy : busy);
            if (((sel != 0) ? w_done : frame_done) === 1'b1) done_j = jj;
            if (jj == opt_mid_start) set_start(sel, 1'b1);
            if (done_j >= 0 && opt_start_on_done) set_start(sel, 1'b1);
            cur = (jj - 2) / (bpp * TBIT);
            if (jj == opt_wr_j) write_now(2, wr_val2, cur);
            if (jj == opt_wr_j + 1) write_now(5, wr_val5, cur);
            if (jj == opt_rst_j) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_sk_now", sk, 0);
                check_eq("rst_busy_now", busy, 0);
                aborted = 1;
            end
        end
        if (aborted) begin
            bad = 0;
            repeat (3) begin
                @(negedge clk);
                if (frame_done !== 1'b0 || busy !== 1'b0 || sk !== 1'b0) bad++;
            end
            check_eq("rst_hold_quiet", bad, 0);
            rst_n = 1'b1;
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
            end
            check_eq("rst_no_done", bad, 0);
            return;
        end
        @(negedge clk);
        set_start(sel, 1'b0);
        check_eq("done_at", done_j, flen);
        for (int k = 0; k < nb; k++) begin
            lead = 0; tot = 0; inrun = 1;
            for (int t = 0; t < TBIT; t++) begin
                j = 2 + k * TBIT + t;
                s = (j - 1 < smp_sk.size()) ? smp_sk[j - 1] : 1'b0;
                if (s) tot++;
                if (s && inrun) lead++;
                else inrun = 0;
            end
            hi = exp_bit(k, bpp, br) ? T1H : T0H;
            check_eq($sformatf("px%0d_bit%0d_high", k / bpp, k % bpp), (lead == tot) ? tot : 999, hi);
        end
        bad = 0;
        for (int jj = 1; jj <= flen && jj - 1 < smp_sk.size(); jj++)
            if ((jj == 1 || jj >= 2 + nb * TBIT) && smp_sk[jj - 1]) bad++;
        check_eq("latch_low", bad, 0);
        bad = 0;
        for (int jj = 1; jj < flen && jj - 1 < smp_busy.size(); jj++)
            if (!smp_busy[jj - 1]) bad++;
        check_eq("busy_high", bad, 0);
        check_eq("busy_end", (flen - 1 < smp_busy.size()) ? smp_busy[flen - 1] : 1'b1, 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (((sel != 0) ? w_busy : busy) !== 1'b0) bad++;
        end
        check_eq("no_refire", bad, 0);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_sk", sk, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", frame_done, 0);
        check_eq("reset_w_sk", w_sk, 0);
        check_eq("reset_w_busy", w_busy, 0);
        check_eq("reset_w_done", w_done, 0);
        rst_n = 1'b1;

        // All-zero buffer at full brightness.
        for (int p = 0; p < NPIX; p++) write_idle(p, 24'h0);
        bright = 8'd255;
        run_frame(0, NPIX, 24, RST_MAIN);

        // Marker pixel, start requests while busy and on FrameDone, writes mid-frame.
        write_idle(0, 24'h800001);
        for (int p = 1; p < NPIX; p++) write_idle(p, 24'($urandom));
        opt_mid_start = 3000;
        opt_start_on_done = 1;
        opt_wr_j = 2 + 2 * 24 * TBIT + 700;
        wr_val2 = 24'($urandom);
        wr_val5 = 24'($urandom);
        run_frame(0, NPIX, 24, RST_MAIN);
        opt_mid_start = -1;
        opt_start_on_done = 0;
        opt_wr_j = -1;

        // Saturated pixel at half brightness.
        write_idle(0, 24'hFFFFFF);
        bright = 8'd128;
        run_frame(0, NPIX, 24, RST_MAIN);

        // Random frame aborted by reset during pixel 3.
        for (int p = 0; p < NPIX; p++) write_idle(p, 24'($urandom));
        bright = 8'($urandom_range(1, 254));
        opt_rst_j = 2 + 3 * 24 * TBIT + 500;
        run_frame(0, NPIX, 24, RST_MAIN);
        opt_rst_j = -1;

        // Buffer survives reset; fresh frame from pixel 0.
        bright = 8'($urandom_range(1, 254));
        run_frame(0, NPIX, 24, RST_MAIN);

        // GRBW single-pixel chain: out-of-range write ignored, zero and random brightness.
        w_write(0, $urandom);
        w_write(1, $urandom);
        bright = 8'd0;
        run_frame(1, 1, 32, RST_W);
        w_write(0, $urandom);
        bright = 8'($urandom_range(1, 254));
        run_frame(1, 1, 32, RST_W);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
